// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Port numbering fixes which requester is eligible while the loader holds boot_lock.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  localparam int DEF_NREQ    = 3;
  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;
  localparam int DEF_MEM_LAT = 4;

  localparam int PORT_LOADER = 0;
  localparam int PORT_CORE   = 1;
  localparam int PORT_DMA    = 2;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and memory-controller bundle for the RAM arbiter.
// slave = the arbiter; master = the requesters plus the memory_controller read-data return.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);
  logic                boot_lock;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_we;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_re;
  logic                mem_we;
  logic [DW-1:0]       mem_rdata;

  modport master (
    output boot_lock, req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    input  boot_lock, req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible port above last_grant, wrapping.
// Zero latency; no backpressure, the caller decides whether to act on the pick.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] gnt,
  output logic            any
);

  int idx;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!any && elig[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the memory_controller port among NREQ requesters; request-to-response MEM_LAT+1 cycles.
// One access in flight; other requesters wait with valid held, one idle cycle between accesses.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MEM_LAT) + 1;

  arb_state_t      state;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] cur;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [IW-1:0]   g_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;

  assign elig = bus.req_valid & (bus.boot_lock ? (NREQ'(1) << PORT_LOADER) : '1);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .elig       (elig),
    .last_grant (last_grant),
    .gnt        (gnt),
    .any        (any)
  );

  always_comb begin
    g_idx     = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_idx     = IW'(i);
        sel_addr  = bus.req_addr[i*AW +: AW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
        sel_we    = bus.req_we[i];
      end
    end
  end

  // Strobes are registered at the grant edge, so they cover exactly the MEM_LAT BUSY cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= IW'(NREQ - 1);
      cnt           <= '0;
      cur           <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any) begin
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
            bus.mem_re    <= ~sel_we;
            bus.mem_we    <= sel_we;
            last_grant    <= g_idx;
            cur           <= gnt;
            bus.req_ready <= gnt;
            cnt           <= CW'(MEM_LAT - 1);
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            bus.rsp_rdata <= bus.mem_rdata;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.rsp_valid <= cur;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          bus.mem_re <= 1'b0;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single memory_controller CPU-side port between several requesters: program loader, main CPU core and a spare DMA/debug port. It replaces the static loader/core RAM mux in the top level. Requests are granted round-robin, or port 0 only while `boot_lock` is high. The arbiter sequences each access: it holds address, data and strobes stable for a fixed controller latency, then returns a one-cycle response to the winner.

## Interface
Parameters:
- `NREQ`, 3: number of requesters; port 0 = loader, 1 = core, 2 = DMA/debug.
- `AW`, 16: word address width.
- `DW`, 16: data width.
- `MEM_LAT`, 4: cycles memory_controller needs strobes held per word access; must be ≥1.

Ports:
- `clk` in 1: single clock (global 50 MHz domain).
- `rst` in 1: reset, asynchronous, active-low.
- `boot_lock` in 1: while high, only port 0 is eligible.
- `req_valid` in NREQ: request pending, one bit per port.
- `req_we` in NREQ: 1 = write, 0 = read, per port.
- `req_addr` in NREQ*AW: packed addresses; port i uses bits [i*AW +: AW].
- `req_wdata` in NREQ*DW: packed write data, same packing as `req_addr`.
- `req_ready` out NREQ: one-hot one-cycle pulse when a port's request is accepted.
- `rsp_valid` out NREQ: one-hot one-cycle pulse when that port's access completes.
- `rsp_rdata` out DW: read data, shared; valid only with a `rsp_valid` bit.
- `mem_addr` out AW: to memory_controller.
- `mem_wdata` out DW: to memory_controller.
- `mem_re` out 1: read strobe to memory_controller.
- `mem_we` out 1: write strobe to memory_controller.
- `mem_rdata` in DW: from memory_controller.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - Eligible ports are `req_valid & (boot_lock ? 1 : all ones)`.
  - If none are eligible, stay in IDLE.
  - Otherwise pick the winner `g`: the first eligible port searching upward from `last_grant+1` modulo NREQ.
  - Latch addr, wdata and we of `g`; set `last_grant=g`; pulse `req_ready[g]`; load `cnt=MEM_LAT-1`; go to BUSY.
- BUSY:
  - `mem_addr`/`mem_wdata` come from the latched values.
  - `mem_re = ~we_l` and `mem_we = we_l`, held constant.
  - Each cycle `cnt` decrements. At `cnt==0`, capture `mem_rdata` into `rsp_rdata` and go to RESP.
- RESP:
  - Strobes low; pulse `rsp_valid[g]`; go to IDLE.
  - `rsp_rdata` holds its value until the next capture. On writes it carries don't-care captured data.
- Requester rules:
  - Hold valid, we, addr and wdata stable until `req_ready` is seen.
  - Dropping valid before `req_ready` withdraws the request with no side effect.
  - `req_valid` is ignored outside IDLE.
- `boot_lock` changing during BUSY/RESP does not abort the access in flight. It only affects the next arbitration.
- At most one strobe is ever high. Strobes are never high outside BUSY.
- `cnt` width is clog2(MEM_LAT)+1. When MEM_LAT=1, BUSY lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, `last_grant=NREQ-1` (port 0 wins first), `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `mem_addr=0`, `mem_wdata=0`, `mem_re=0`, `mem_we=0`.
- Asserting reset mid-BUSY drops strobes immediately (asynchronous). No response is issued for the aborted access.
- Edge E0 samples `req_valid` in IDLE. `req_ready[g]` is high for the cycle after E0.
- `mem_re`/`mem_we` are high for exactly MEM_LAT cycles after E0.
- `mem_rdata` is sampled at edge E0+MEM_LAT. `rsp_valid[g]` is high for the cycle after that edge.
- Request-to-response latency is MEM_LAT+1 cycles.
- Sustained throughput is one access per MEM_LAT+2 cycles, because one IDLE cycle occurs between transactions.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `ram_arb_pkg`: state enum (IDLE, BUSY, RESP), default NREQ/AW/DW/MEM_LAT constants, port-index constants `PORT_LOADER=0`, `PORT_CORE=1`, `PORT_DMA=2`.
- Sub-module `rr_pick`: purely combinational, parameterised by NREQ. Inputs: eligible mask and `last_grant`. Outputs: one-hot winner, `any`. It is reused by the future interrupt controller.
- Top-level integration: replace the `~initial_rst` address/data/we mux. Drive `boot_lock` from `~initial_rst`.

## Test plan
- Core read, MEM_LAT=4, addr 0x1234, `mem_rdata` driven 0xBEEF -> `req_ready[1]` at cycle 1, `mem_re` high for cycles 1–4, `rsp_valid[1]` at cycle 5 with `rsp_rdata=0xBEEF`.
- Write from port 2, addr 0x0042, data 0xA5A5 -> `mem_we` high 4 cycles with `mem_addr=0x0042` and `mem_wdata=0xA5A5`; `mem_re` stays 0.
- All three ports request continuously from reset -> grant order 0,1,2,0,1,2; accepts spaced 6 cycles apart.
- `boot_lock=1` with ports 1 and 2 valid -> no grant; then port 0 valid -> granted. Drop `boot_lock` during that BUSY -> access completes, then port 1 is granted.
- Reset pulled low during BUSY cycle 2 -> strobes 0 asynchronously, no `rsp_valid`. After release, pending port 0 is granted first.
- Port 1 drops valid in the same cycle port 0 is granted -> port 1 receives no `req_ready` and no `rsp_valid`.
